// File: rtl/sequenciador_es.sv
// I/O and disk sequencer: stalls the fetch for IN (user button) and disk reads, and drives OUT and HALT.
// Optional disk timeout is built only when SEQUENCIADOR_ES_HD_TIMEOUT_EN is defined.
module sequenciador_es #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_to_reg,
    input  logic              reg_to_disp,
    input  logic              halt,
    input  logic              hd_instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_enter,
    input  logic              hd_ack,
    input  logic [DATA_W-1:0] hd_rdata,
    output logic              pc_en,
    output logic              io_wr_en,
    output logic [DATA_W-1:0] io_wr_data,
    output logic              hd_req,
    output logic [DATA_W-1:0] disp_data,
    output logic              halted,
    output logic              hd_err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_HD_WAIT = 3'd2,
        ST_HD_DONE = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              btn_s1_q, btn_s2_q, btn_s3_q;
    logic              enter_edge;
    logic              timeout;

    // btn_s3_q remembers the previous synchronized level so a held button never counts as a press.
    assign enter_edge = btn_s2_q & ~btn_s3_q;

`ifdef SEQUENCIADOR_ES_HD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       hd_err_q, hd_err_d;

    // An hd_ack in the last allowed cycle takes precedence over the timeout.
    assign timeout = (state_q == ST_HD_WAIT) && !hd_ack && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        hd_err_d  = hd_err_q;
        if (state_q != ST_HD_WAIT) begin
            tmo_cnt_d = 8'd0;
        end else if (!hd_ack) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        if (timeout) begin
            hd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
            hd_err_q  <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            hd_err_q  <= hd_err_d;
        end
    end

    assign hd_err = hd_err_q;
`else
    assign timeout = 1'b0;
    assign hd_err  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        disp_d     = disp_q;
        rdata_d    = rdata_q;
        pc_en      = 1'b0;
        io_wr_en   = 1'b0;
        io_wr_data = '0;
        hd_req     = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (hd_instr) begin
                    state_d = ST_HD_WAIT;
                end else if (sw_to_reg) begin
                    state_d = ST_WAIT_IN;
                end else begin
                    pc_en = 1'b1;
                    if (reg_to_disp) begin
                        disp_d = rs_data;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (enter_edge) begin
                    pc_en      = 1'b1;
                    io_wr_en   = 1'b1;
                    io_wr_data = sw_data;
                    state_d    = ST_RUN;
                end
            end
            ST_HD_WAIT: begin
                hd_req = 1'b1;
                if (hd_ack) begin
                    rdata_d = hd_rdata;
                    state_d = ST_HD_DONE;
                end else if (timeout) begin
                    pc_en   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HD_DONE: begin
                pc_en      = 1'b1;
                io_wr_en   = 1'b1;
                io_wr_data = rdata_q;
                state_d    = ST_RUN;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            disp_q   <= '0;
            rdata_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            rdata_q  <= rdata_d;
            btn_s1_q <= btn_enter;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
        end
    end

    assign disp_data = disp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sequenciador_es.sv
// Directed bench for sequenciador_es: OUT, IN with button synchronizer, disk read, timeout, halt and reset.
module tb_sequenciador_es;

    localparam int DW = 32;

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_WAIT_IN = 3'd1;
    localparam logic [2:0] S_HD_WAIT = 3'd2;
    localparam logic [2:0] S_HD_DONE = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sw_to_reg, reg_to_disp, halt, hd_instr;
    logic [DW-1:0] rs_data, sw_data, hd_rdata;
    logic          btn_enter, hd_ack;
    logic          pc_en, io_wr_en, hd_req, halted, hd_err;
    logic [DW-1:0] io_wr_data, disp_data;
    logic [2:0]    dbg_state;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sequenciador_es #(.DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_to_reg(sw_to_reg), .reg_to_disp(reg_to_disp), .halt(halt), .hd_instr(hd_instr),
        .rs_data(rs_data), .sw_data(sw_data), .btn_enter(btn_enter),
        .hd_ack(hd_ack), .hd_rdata(hd_rdata),
        .pc_en(pc_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data), .hd_req(hd_req),
        .disp_data(disp_data), .halted(halted), .hd_err(hd_err), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are checked 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        settle();
        chk("rst_state", dbg_state, S_RUN);
        chk("rst_hd_req", hd_req, 1'b0);
        chk("rst_io_wr_en", io_wr_en, 1'b0);
        chk("rst_halted", halted, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sw_to_reg = 0; reg_to_disp = 0; halt = 0; hd_instr = 0;
        rs_data = '0; sw_data = '0; hd_rdata = '0; btn_enter = 0; hd_ack = 0;
        settle();
        chk("reset_pc_en", pc_en, 1'b1);
        chk("reset_disp", disp_data, '0);
        chk("reset_hd_err", hd_err, 1'b0);
        chk("reset_halted", halted, 1'b0);
        chk("reset_io_wr_data", io_wr_data, '0);
        sw_to_reg = 1;
        settle();
        chk("reset_pc_en_in", pc_en, 1'b0);
        chk("reset_state_hold", dbg_state, S_RUN);
        sw_to_reg = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_state", dbg_state, S_RUN);
        chk("idle_pc_en", pc_en, 1'b1);

        // OUT
        reg_to_disp = 1; rs_data = 32'h0000_00A5;
        settle();
        chk("out_pc_en", pc_en, 1'b1);
        tick();
        reg_to_disp = 0; rs_data = 32'h1111_1111;
        settle();
        chk("out_disp", disp_data, 32'hA5);
        chk("out_state", dbg_state, S_RUN);
        chk("out_no_wr", io_wr_en, 1'b0);

        // IN, button pressed 10 cycles later
        sw_to_reg = 1; sw_data = 32'h1234;
        settle();
        chk("in_pc_en_decode", pc_en, 1'b0);
        tick();
        sw_to_reg = 0;
        settle();
        chk("in_state", dbg_state, S_WAIT_IN);
        for (int i = 0; i < 10; i++) begin
            chk("in_wait_pc_en", pc_en, 1'b0);
            tick();
        end
        btn_enter = 1;
        tick();
        chk("in_sync_pc_en", pc_en, 1'b0);
        tick();
        chk("in_done_pc_en", pc_en, 1'b1);
        chk("in_done_wr_en", io_wr_en, 1'b1);
        chk("in_done_wr_data", io_wr_data, 32'h1234);
        tick();
        chk("in_back_run", dbg_state, S_RUN);
        chk("in_wr_once", io_wr_en, 1'b0);
        chk("in_wr_data_zero", io_wr_data, '0);

        // IN with the button already held: needs release and re-press
        tick(); tick();
        sw_data = 32'h5A5A;
        sw_to_reg = 1;
        tick();
        sw_to_reg = 0;
        for (int i = 0; i < 5; i++) begin
            chk("held_pc_en", pc_en, 1'b0);
            chk("held_no_wr", io_wr_en, 1'b0);
            tick();
        end
        btn_enter = 0;
        for (int i = 0; i < 3; i++) begin
            chk("release_pc_en", pc_en, 1'b0);
            tick();
        end
        btn_enter = 1;
        tick();
        chk("repress_sync", pc_en, 1'b0);
        tick();
        chk("repress_wr_en", io_wr_en, 1'b1);
        chk("repress_wr_data", io_wr_data, 32'h5A5A);
        tick();
        btn_enter = 0;
        chk("repress_state", dbg_state, S_RUN);

        // hd_ack outside HD_WAIT is ignored
        hd_ack = 1; hd_rdata = 32'hBAD0_BAD0;
        tick();
        hd_ack = 0; hd_rdata = '0;
        settle();
        chk("stray_ack_state", dbg_state, S_RUN);
        chk("stray_ack_wr", io_wr_en, 1'b0);

        // Disk read, ack after 5 cycles
        hd_instr = 1;
        settle();
        chk("hd_pc_en_decode", pc_en, 1'b0);
        chk("hd_req_decode", hd_req, 1'b0);
        tick();
        hd_instr = 0;
        for (int i = 0; i < 4; i++) begin
            chk("hd_req_wait", hd_req, 1'b1);
            chk("hd_pc_en_wait", pc_en, 1'b0);
            tick();
        end
        hd_ack = 1; hd_rdata = 32'hDEADBEEF;
        settle();
        chk("hd_req_ack_cycle", hd_req, 1'b1);
        tick();
        hd_ack = 0; hd_rdata = '0;
        settle();
        chk("hd_done_state", dbg_state, S_HD_DONE);
        chk("hd_done_wr_en", io_wr_en, 1'b1);
        chk("hd_done_wr_data", io_wr_data, 32'hDEADBEEF);
        chk("hd_done_pc_en", pc_en, 1'b1);
        chk("hd_done_req", hd_req, 1'b0);
        tick();
        chk("hd_after_state", dbg_state, S_RUN);
        chk("hd_after_wr", io_wr_en, 1'b0);

`ifdef SEQUENCIADOR_ES_HD_TIMEOUT_EN
        // Timeout after 4 HD_WAIT cycles
        hd_instr = 1;
        tick();
        hd_instr = 0;
        for (int i = 0; i < 3; i++) begin
            chk("tmo_wait_pc_en", pc_en, 1'b0);
            chk("tmo_wait_req", hd_req, 1'b1);
            tick();
        end
        chk("tmo_cycle_pc_en", pc_en, 1'b1);
        chk("tmo_cycle_wr", io_wr_en, 1'b0);
        chk("tmo_cycle_err_pre", hd_err, 1'b0);
        tick();
        chk("tmo_state", dbg_state, S_RUN);
        chk("tmo_hd_err", hd_err, 1'b1);
        chk("tmo_req", hd_req, 1'b0);
        chk("tmo_no_wr", io_wr_en, 1'b0);

        // Ack in the timeout cycle wins
        hd_instr = 1;
        tick();
        hd_instr = 0;
        tick(); tick(); tick();
        hd_ack = 1; hd_rdata = 32'hCAFE_F00D;
        settle();
        chk("tmo_ack_pc_en", pc_en, 1'b0);
        tick();
        hd_ack = 0; hd_rdata = '0;
        settle();
        chk("tmo_ack_state", dbg_state, S_HD_DONE);
        chk("tmo_ack_wr_data", io_wr_data, 32'hCAFE_F00D);
        chk("tmo_err_sticky", hd_err, 1'b1);
        tick();
`endif

        // Disk with no ack: without the timeout it stays; reset aborts with no write
        hd_instr = 1;
        tick();
        hd_instr = 0;
`ifndef SEQUENCIADOR_ES_HD_TIMEOUT_EN
        for (int i = 0; i < 10; i++) tick();
        chk("notmo_state", dbg_state, S_HD_WAIT);
        chk("notmo_req", hd_req, 1'b1);
        chk("notmo_err", hd_err, 1'b0);
`else
        tick();
        chk("abort_state", dbg_state, S_HD_WAIT);
`endif
        reset_pulse();
        chk("abort_run", dbg_state, S_RUN);
        chk("abort_err_clr", hd_err, 1'b0);
        chk("abort_no_wr", io_wr_en, 1'b0);

        // Reset during WAIT_IN aborts the IN
        sw_to_reg = 1;
        tick();
        sw_to_reg = 0;
        reset_pulse();
        chk("in_abort_state", dbg_state, S_RUN);

        // halt together with hd_instr
        halt = 1; hd_instr = 1;
        settle();
        chk("halt_pc_en", pc_en, 1'b0);
        chk("halt_hd_req", hd_req, 1'b0);
        tick();
        halt = 0; hd_instr = 0;
        for (int i = 0; i < 4; i++) begin
            sw_to_reg = (i == 1);
            hd_instr  = (i == 2);
            settle();
            chk("halted_flag", halted, 1'b1);
            chk("halted_req", hd_req, 1'b0);
            chk("halted_pc_en", pc_en, 1'b0);
            tick();
        end
        sw_to_reg = 0; hd_instr = 0;
        chk("halted_state", dbg_state, S_HALTED);
        reset_pulse();
        chk("unhalt_flag", halted, 1'b0);
        chk("unhalt_pc_en", pc_en, 1'b1);
        chk("unhalt_disp", disp_data, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
